// File: rtl/ysyx_23060236_wbu.sv
// Write-back unit: commits one instruction result to the register file and CSR file,
// then hands the next PC to fetch. One instruction in flight: IDLE -> EXEC -> REDIRECT.
module ysyx_23060236_wbu #(
    parameter logic [31:0] RESET_PC = 32'h30000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_alu_res,
    input  logic [31:0] in_rs1,
    input  logic [1:0]  in_csr_op,
    input  logic [11:0] in_csr_addr,
    input  logic        in_ecall,
    input  logic        in_mret,
    input  logic        in_br_taken,
    output logic [11:0] csr_imm,
    output logic [31:0] csr_wdata,
    output logic        csr_enable,
    output logic        csr_ecall,
    output logic        csr_mret,
    output logic [31:0] csr_epc,
    output logic        csr_valid,
    input  logic [31:0] csr_rdata,
    input  logic [31:0] csr_jump,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] out_pc,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {IDLE, EXEC, REDIRECT} state_t;

    state_t      state, next_state;
    logic [31:0] pc_q, alu_q, rs1_q, npc_q, pc_plus4;
    logic [4:0]  rd_q;
    logic [1:0]  op_q;
    logic [11:0] addr_q;
    logic        ecall_q, mret_q, br_q;
    logic        is_ecall, is_mret;
    logic [31:0] wdata_calc, next_pc;

    // Reset from any state lands in REDIRECT so fetch always gets RESET_PC first.
    always_ff @(posedge clock) begin
        if (reset) state <= REDIRECT;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (in_valid) next_state = EXEC;
            EXEC:     next_state = REDIRECT;
            REDIRECT: if (out_ready) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (in_valid && in_ready) begin
            pc_q    <= in_pc;
            rd_q    <= in_rd;
            alu_q   <= in_alu_res;
            rs1_q   <= in_rs1;
            op_q    <= in_csr_op;
            addr_q  <= in_csr_addr;
            ecall_q <= in_ecall;
            mret_q  <= in_mret;
            br_q    <= in_br_taken;
        end
    end

    // A CSR op suppresses ecall/mret; ecall wins over mret.
    assign pc_plus4 = pc_q + 32'd4;
    assign is_ecall = ecall_q && (op_q == 2'b00);
    assign is_mret  = mret_q && !ecall_q && (op_q == 2'b00);

    always_comb begin
        case (op_q)
            2'b01:   wdata_calc = rs1_q;
            2'b10:   wdata_calc = csr_rdata | rs1_q;
            2'b11:   wdata_calc = csr_rdata & ~rs1_q;
            default: wdata_calc = 32'd0;
        endcase
    end

    always_comb begin
        if (is_ecall || is_mret) next_pc = csr_jump;
        else if (br_q)           next_pc = alu_q;
        else                     next_pc = pc_plus4;
    end

    always_ff @(posedge clock) begin
        if (reset)              npc_q <= RESET_PC;
        else if (state == EXEC) npc_q <= next_pc;
    end

    // Every strobe is masked by reset so an aborted instruction never commits.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        csr_valid  = 1'b0;
        csr_enable = 1'b0;
        csr_ecall  = 1'b0;
        csr_mret   = 1'b0;
        rf_wen     = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: in_ready = 1'b1;
                EXEC: begin
                    csr_valid  = 1'b1;
                    csr_enable = (op_q != 2'b00);
                    csr_ecall  = is_ecall;
                    csr_mret   = is_mret;
                    rf_wen     = (rd_q != 5'd0);
                end
                REDIRECT: out_valid = 1'b1;
                default: ;
            endcase
        end
    end

    assign csr_imm   = addr_q;
    assign csr_epc   = pc_q;
    assign csr_wdata = (state == EXEC) ? wdata_calc : 32'd0;
    assign rf_waddr  = rd_q;
    // Old CSR value goes to rd, matching csrr* read-before-write semantics.
    assign rf_wdata  = (op_q != 2'b00) ? csr_rdata : (br_q ? pc_plus4 : alu_q);
    assign out_pc    = npc_q;

endmodule

// File: tb/tb_ysyx_23060236_wbu.sv
// Bench for ysyx_23060236_wbu: directed scenarios plus randomized transactions
// compared against a transaction-level reference model.
module tb_ysyx_23060236_wbu;

    localparam logic [31:0] RST_PC = 32'h30000000;

    logic        clock = 1'b0;
    logic        reset, in_valid, in_ready;
    logic [31:0] in_pc, in_alu_res, in_rs1;
    logic [4:0]  in_rd;
    logic [1:0]  in_csr_op;
    logic [11:0] in_csr_addr;
    logic        in_ecall, in_mret, in_br_taken;
    logic [11:0] csr_imm;
    logic [31:0] csr_wdata, csr_epc, csr_rdata, csr_jump;
    logic        csr_enable, csr_ecall, csr_mret, csr_valid;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, out_pc;
    logic        out_valid, out_ready;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rs1;
        logic [1:0]  op;
        logic [11:0] addr;
        logic        ecall;
        logic        mret;
        logic        br;
    } txn_t;

    ysyx_23060236_wbu #(.RESET_PC(RST_PC)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rd(in_rd), .in_alu_res(in_alu_res), .in_rs1(in_rs1),
        .in_csr_op(in_csr_op), .in_csr_addr(in_csr_addr),
        .in_ecall(in_ecall), .in_mret(in_mret), .in_br_taken(in_br_taken),
        .csr_imm(csr_imm), .csr_wdata(csr_wdata), .csr_enable(csr_enable),
        .csr_ecall(csr_ecall), .csr_mret(csr_mret), .csr_epc(csr_epc),
        .csr_valid(csr_valid), .csr_rdata(csr_rdata), .csr_jump(csr_jump),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .out_pc(out_pc), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    function automatic txn_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                input logic [31:0] alu, input logic [31:0] rs1,
                                input logic [1:0] op, input logic [11:0] addr,
                                input logic ecall, input logic mret, input logic br);
        txn_t t;
        t.pc = pc; t.rd = rd; t.alu = alu; t.rs1 = rs1; t.op = op;
        t.addr = addr; t.ecall = ecall; t.mret = mret; t.br = br;
        return t;
    endfunction

    // Reference: what an instruction commits, in instruction-set terms.
    task automatic model(input txn_t t, input logic [31:0] rdata, input logic [31:0] jump,
                         output logic [119:0] expv, output logic [31:0] npc);
        logic        trap_e, ret_e, has_csr;
        logic [31:0] cw, link, wb;
        has_csr = (t.op != 2'b00);
        trap_e  = !has_csr && t.ecall;
        ret_e   = !has_csr && !t.ecall && t.mret;
        case (t.op)
            2'b01:   cw = t.rs1;
            2'b10:   cw = rdata | t.rs1;
            2'b11:   cw = rdata & ~t.rs1;
            default: cw = 32'd0;
        endcase
        link = t.pc + 32'd4;
        if (has_csr)   wb = rdata;
        else if (t.br) wb = link;
        else           wb = t.alu;
        if (trap_e || ret_e) npc = jump;
        else if (t.br)       npc = t.alu;
        else                 npc = link;
        expv = {1'b0, 1'b0, 1'b1, has_csr, trap_e, ret_e, (t.rd != 5'd0),
                t.rd, wb, cw, t.addr, t.pc};
    endtask

    task automatic drive_in(input txn_t t);
        in_pc = t.pc; in_rd = t.rd; in_alu_res = t.alu; in_rs1 = t.rs1;
        in_csr_op = t.op; in_csr_addr = t.addr;
        in_ecall = t.ecall; in_mret = t.mret; in_br_taken = t.br;
    endtask

    task automatic scramble_in();
        in_pc = $urandom; in_rd = 5'($urandom); in_alu_res = $urandom; in_rs1 = $urandom;
        in_csr_op = 2'($urandom); in_csr_addr = 12'($urandom);
        in_ecall = 1'($urandom); in_mret = 1'($urandom); in_br_taken = 1'($urandom);
    endtask

    // Accept at IDLE, check EXEC strobes, then REDIRECT with `stall` cycles of backpressure.
    task automatic do_txn(input string name, input txn_t t, input logic [31:0] rdata,
                          input logic [31:0] jump, input int stall);
        logic [119:0] expv, obs;
        logic [31:0]  npc;
        int n;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clock); n++; end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s idle_wait in_ready=%b required 1", name, in_ready);
        end
        drive_in(t);
        in_valid = 1'b1; csr_rdata = rdata; csr_jump = jump; out_ready = 1'b0;
        @(negedge clock);
        in_valid = 1'b0;
        scramble_in();
        #1;
        model(t, rdata, jump, expv, npc);
        obs = {in_ready, out_valid, csr_valid, csr_enable, csr_ecall, csr_mret, rf_wen,
               rf_waddr, rf_wdata, csr_wdata, csr_imm, csr_epc};
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s exec got=%h required=%h", name, obs, expv);
        end
        @(negedge clock);
        csr_rdata = $urandom; csr_jump = $urandom;
        for (int i = 0; i <= stall; i++) begin
            #1;
            checks++;
            if ({in_ready, out_valid, csr_valid, rf_wen, out_pc} !== {4'b0100, npc}) begin
                failures++;
                $display("FAIL %s redirect[%0d] rdy=%b ov=%b cv=%b wen=%b pc=%h required 0100 pc=%h",
                         name, i, in_ready, out_valid, csr_valid, rf_wen, out_pc, npc);
            end
            if (i == stall) out_ready = 1'b1;
            @(negedge clock);
        end
        out_ready = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL %s back_to_idle rdy=%b ov=%b required rdy=1 ov=0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
        scramble_in();
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if ({in_ready, out_valid, csr_valid, csr_enable, csr_ecall, csr_mret, rf_wen} !== 7'b0) begin
            failures++;
            $display("FAIL reset_inactive got=%b required 0000000",
                     {in_ready, out_valid, csr_valid, csr_enable, csr_ecall, csr_mret, rf_wen});
        end
        in_valid = 1'b0;
        reset = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, out_pc} !== {2'b01, RST_PC}) begin
            failures++;
            $display("FAIL reset_release rdy=%b ov=%b pc=%h required rdy=0 ov=1 pc=%h",
                     in_ready, out_valid, out_pc, RST_PC);
        end
        @(negedge clock);
        out_ready = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_to_idle rdy=%b ov=%b required rdy=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        do_txn("addi", mk(32'h100, 5'd5, 32'd7, 32'h0, 2'b00, 12'h0, 0, 0, 0), 32'h0, 32'h0, 0);
        do_txn("csrrs", mk(32'h120, 5'd3, 32'h0, 32'h8, 2'b10, 12'h300, 0, 0, 0), 32'h1800, 32'h0, 0);
        do_txn("csrrc", mk(32'h124, 5'd4, 32'h0, 32'h8, 2'b11, 12'h300, 0, 0, 0), 32'h1808, 32'h0, 1);
        do_txn("ecall", mk(32'h200, 5'd0, 32'h0, 32'h0, 2'b00, 12'h0, 1, 0, 0), 32'h0, 32'h80, 0);
        do_txn("mret", mk(32'h80, 5'd0, 32'h0, 32'h0, 2'b00, 12'h302, 0, 1, 0), 32'h0, 32'h204, 0);
        do_txn("ecall_over_mret", mk(32'h90, 5'd0, 32'h0, 32'h0, 2'b00, 12'h0, 1, 1, 0), 32'h0, 32'h88, 0);
        do_txn("csr_over_ecall", mk(32'h94, 5'd6, 32'h0, 32'h5, 2'b01, 12'h305, 1, 1, 0), 32'hABCD, 32'h88, 0);
    endtask

    task automatic test_backpressure();
        do_txn("jal_stall", mk(32'h40, 5'd1, 32'h400, 32'h0, 2'b00, 12'h0, 0, 0, 1), 32'h0, 32'h0, 3);
    endtask

    task automatic test_wrap();
        do_txn("pc_wrap", mk(32'hFFFFFFFC, 5'd2, 32'h11, 32'h0, 2'b00, 12'h0, 0, 0, 0), 32'h0, 32'h0, 0);
        do_txn("link_wrap", mk(32'hFFFFFFFC, 5'd2, 32'h800, 32'h0, 2'b00, 12'h0, 0, 0, 1), 32'h0, 32'h0, 0);
    endtask

    task automatic test_reset_mid_exec();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clock); n++; end
        drive_in(mk(32'h500, 5'd9, 32'h0, 32'hF0, 2'b01, 12'h341, 0, 0, 0));
        in_valid = 1'b1; csr_rdata = 32'h55; out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0; reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, csr_valid, csr_enable, csr_ecall, csr_mret, rf_wen} !== 7'b0) begin
            failures++;
            $display("FAIL reset_mid_exec got=%b required 0000000",
                     {in_ready, out_valid, csr_valid, csr_enable, csr_ecall, csr_mret, rf_wen});
        end
        @(negedge clock);
        reset = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if ({out_valid, csr_valid, rf_wen, out_pc} !== {3'b100, RST_PC}) begin
            failures++;
            $display("FAIL restart_pc ov=%b cv=%b wen=%b pc=%h required ov=1 cv=0 wen=0 pc=%h",
                     out_valid, csr_valid, rf_wen, out_pc, RST_PC);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        txn_t t;
        for (int k = 0; k < 40; k++) begin
            t = mk($urandom, 5'($urandom), $urandom, $urandom, 2'($urandom), 12'($urandom),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'($urandom));
            if ($urandom_range(0, 4) == 0) t.rd = 5'd0;
            do_txn($sformatf("rand%0d", k), t, $urandom, $urandom, $urandom_range(0, 2));
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
        csr_rdata = 32'h0; csr_jump = 32'h0;
        scramble_in();
        @(negedge clock);
        test_reset();
        test_directed();
        test_backpressure();
        test_wrap();
        test_reset_mid_exec();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
